// File: rtl/calc_result_bcd_if.sv
// ---------------------------------------------------------------------------
// calc_result_bcd_if
// Request/result bundle between simple_calculator and calc_result_bcd.
//   master (calculator side): drives Start, Clear, Bin, Flag_In;
//                             receives Busy, Valid, Bcd, Blank, Ovf.
//   slave  (converter side) : the mirror image.
// Start    1-cycle conversion request, honoured in IDLE or DONE only
// Clear    synchronous abort, returns the converter to IDLE
// Bin      unsigned binary value, sampled on the Start edge
// Flag_In  calculator overflow flag, sampled with Bin
// Busy     conversion in progress
// Valid    Bcd/Blank/Ovf hold a finished result
// Bcd      packed BCD, digit k at [4k+3:4k], k=0 least significant
// Blank    1 = digit k is a leading zero (Blank[0] is always 0)
// Ovf      Flag_In captured with the converted value
// ---------------------------------------------------------------------------
interface calc_result_bcd_if #(
   parameter int IN_W   = 17,
   parameter int DIGITS = 6
);
   logic                  Start;
   logic                  Clear;
   logic [IN_W-1:0]       Bin;
   logic                  Flag_In;
   logic                  Busy;
   logic                  Valid;
   logic [4*DIGITS-1:0]   Bcd;
   logic [DIGITS-1:0]     Blank;
   logic                  Ovf;

   modport master (
      output Start, Clear, Bin, Flag_In,
      input  Busy, Valid, Bcd, Blank, Ovf
   );

   modport slave (
      input  Start, Clear, Bin, Flag_In,
      output Busy, Valid, Bcd, Blank, Ovf
   );
endinterface

// File: rtl/calc_result_bcd.sv
// ---------------------------------------------------------------------------
// calc_result_bcd
// Converts the calculator's unsigned binary result into packed BCD digits
// for the seven-segment driver, using iterative double dabble (one input bit
// per clock, MSB first). Also produces a leading-zero blanking mask and
// carries the calculator's overflow flag alongside the result.
// Ports:
//   Clk    in   system clock, all state on posedge
//   Reset  in   asynchronous, active-high reset
//   bus    slave side of calc_result_bcd_if (Start/Clear/Bin/Flag_In in,
//          Busy/Valid/Bcd/Blank/Ovf out)
// Timing: Start sampled at edge t0 -> Busy from t0 for IN_W cycles, then one
// cycle in DONE while the result registers load, Valid from edge t0+IN_W+1.
// ---------------------------------------------------------------------------
module calc_result_bcd #(
   parameter int IN_W   = 17,
   parameter int DIGITS = 6
) (
   input  logic               Clk,
   input  logic               Reset,
   calc_result_bcd_if.slave   bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int CAT_W = BCD_W + IN_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   logic [1:0]        state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [IN_W-1:0]   shift_q,   shift_d;
   logic [BCD_W-1:0]  scratch_q, scratch_d;
   logic              ovf_cap_q, ovf_cap_d;
   logic              busy_q,    busy_d;
   logic              valid_q,   valid_d;
   logic [BCD_W-1:0]  bcd_q,     bcd_d;
   logic [DIGITS-1:0] blank_q,   blank_d;
   logic              ovf_q,     ovf_d;

   logic [BCD_W-1:0]  adj;
   logic [CAT_W-1:0]  shifted;
   logic [DIGITS-1:0] blank_calc;
   logic              zero_above;

   // Add-3 correction: each 4-bit digit on its own, no carry between digits.
   always_comb begin
      adj = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
      shifted = {adj, shift_q} << 1;
   end

   // Leading-zero mask: scan from the top digit down; digit 0 is never blanked.
   always_comb begin
      blank_calc = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above    = zero_above & (scratch_q[4*k +: 4] == 4'd0);
         blank_calc[k] = zero_above;
      end
   end

   // NOTE: every next-state signal takes its current value first, so no path
   // through the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      ovf_cap_d = ovf_cap_q;
      busy_d    = busy_q;
      valid_d   = valid_q;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      ovf_d     = ovf_q;

      if (bus.Clear) begin
         // Clear wins over Start and returns everything to the reset picture.
         state_d   = ST_IDLE;
         cnt_d     = '0;
         shift_d   = '0;
         scratch_d = '0;
         ovf_cap_d = 1'b0;
         busy_d    = 1'b0;
         valid_d   = 1'b0;
         bcd_d     = '0;
         blank_d   = BLANK_RST;
         ovf_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.Start) begin
                  // Capture; Bcd/Blank/Ovf keep the old result until reload.
                  state_d   = ST_SHIFT;
                  cnt_d     = CNT_W'(IN_W);
                  shift_d   = bus.Bin;
                  scratch_d = '0;
                  ovf_cap_d = bus.Flag_In;
                  busy_d    = 1'b1;
                  valid_d   = 1'b0;
               end else if (state_q == ST_DONE && !valid_q) begin
                  // First cycle in DONE: publish the finished conversion.
                  bcd_d   = scratch_q;
                  blank_d = blank_calc;
                  ovf_d   = ovf_cap_q;
                  valid_d = 1'b1;
               end
            end
            ST_SHIFT: begin
               scratch_d = shifted[CAT_W-1 -: BCD_W];
               shift_d   = shifted[IN_W-1:0];
               cnt_d     = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         scratch_q <= '0;
         ovf_cap_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= BLANK_RST;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         ovf_cap_q <= ovf_cap_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.Busy  = busy_q;
   assign bus.Valid = valid_q;
   assign bus.Bcd   = bcd_q;
   assign bus.Blank = blank_q;
   assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_calc_result_bcd
// Scoreboard bench for calc_result_bcd. Each accepted Start pushes the
// expected decimal rendering (digits from repeated /10, blank mask from the
// decimal length) into a queue; a monitor pops and compares on each rising
// edge of Valid. Directed checks cover reset, latency, Busy length, ignored
// Start, restart from DONE, async Reset mid-conversion and Clear vs Start.
// ---------------------------------------------------------------------------
module tb_calc_result_bcd;

   localparam int IN_W   = 17;
   localparam int DIGITS = 6;
   localparam int BCD_W  = 4 * DIGITS;
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef struct {
      logic [BCD_W-1:0]  bcd;
      logic [DIGITS-1:0] blank;
      logic              ovf;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic prev_valid = 1'b0;

   always #5 Clk = ~Clk;

   calc_result_bcd_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

   calc_result_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by division, blank mask from decimal length.
   function automatic exp_t model(input int unsigned v, input logic f);
      exp_t        e;
      int unsigned r = v;
      int          len = 0;
      e.bcd = '0;
      for (int k = 0; k < DIGITS; k++) begin
         e.bcd[4*k +: 4] = 4'(r % 10);
         r = r / 10;
      end
      r = v;
      do begin
         len++;
         r = r / 10;
      end while (r != 0);
      for (int k = 0; k < DIGITS; k++) e.blank[k] = (k >= len);
      e.ovf = f;
      return e;
   endfunction

   task automatic start_conv(input logic [IN_W-1:0] b, input logic f, input bit expect_result);
      @(negedge Clk);
      bus.Bin     = b;
      bus.Flag_In = f;
      bus.Start   = 1'b1;
      if (expect_result) sb.push_back(model(int'(b), f));
      @(posedge Clk);
      #1;
      bus.Start   = 1'b0;
      bus.Flag_In = ~f;
      bus.Bin     = IN_W'($urandom);
   endtask

   // Called right after start_conv: counts edges to Valid and cycles of Busy.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = bus.Busy ? 1 : 0;
      while (!bus.Valid && lat < 100) begin
         @(posedge Clk);
         #1;
         lat++;
         if (!bus.Valid && bus.Busy) busy_n++;
      end
      check("valid_timeout", 64'(bus.Valid), 64'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, 64'(bus.Valid), 64'd0);
      check({tag, "_busy"},  64'(bus.Busy),  64'd0);
      check({tag, "_bcd"},   64'(bus.Bcd),   64'd0);
      check({tag, "_blank"}, 64'(bus.Blank), 64'(BLANK_RST));
      check({tag, "_ovf"},   64'(bus.Ovf),   64'd0);
   endtask

   // Monitor: compare against the scoreboard on each rising edge of Valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (bus.Valid && !prev_valid) begin
            check("busy_with_valid", 64'(bus.Busy), 64'd0);
            if (sb.size() == 0) begin
               check("unexpected_valid", 64'(bus.Valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("sb_bcd",   64'(bus.Bcd),   64'(e.bcd));
               check("sb_blank", 64'(bus.Blank), 64'(e.blank));
               check("sb_ovf",   64'(bus.Ovf),   64'(e.ovf));
            end
         end
         prev_valid = bus.Valid;
      end
   end

   initial begin
      int          lat;
      int          busy_n;
      longint      pow10;
      int unsigned corners [9] = '{0, 1, 9, 10, 99, 100, 99999, 100000, 131071};
      logic [IN_W-1:0] b;

      pow10 = 1;
      for (int k = 0; k < DIGITS; k++) pow10 = pow10 * 10;
      if (pow10 <= (longint'(1) << IN_W)) begin
         $display("FAIL digits_range: 10^%0d does not exceed 2^%0d", DIGITS, IN_W);
         $fatal(1, "DIGITS too small for IN_W");
      end

      bus.Start   = 1'b0;
      bus.Clear   = 1'b0;
      bus.Bin     = '0;
      bus.Flag_In = 1'b0;
      Reset       = 1'b1;
      repeat (3) @(negedge Clk);
      check_reset_values("reset");
      Reset = 1'b0;

      // Zero: latency, Busy length, single visible "0".
      start_conv(17'd0, 1'b0, 1'b1);
      wait_done(lat, busy_n);
      check("zero_latency", 64'(lat), 64'd18);
      check("zero_busy_len", 64'(busy_n), 64'd17);
      repeat (5) @(posedge Clk);
      #1;
      check("done_hold_valid", 64'(bus.Valid), 64'd1);
      check("done_hold_bcd", 64'(bus.Bcd), 64'h000000);

      // Maximum input, restarted from DONE.
      start_conv(17'h1FFFF, 1'b0, 1'b1);
      wait_done(lat, busy_n);
      check("max_latency", 64'(lat), 64'd18);
      check("max_busy_len", 64'(busy_n), 64'd17);

      // Overflow flag captured at Start; later toggling is ignored.
      start_conv(17'd42, 1'b1, 1'b1);
      wait_done(lat, busy_n);
      check("ovf42_latency", 64'(lat), 64'd18);

      // Start during SHIFT is ignored.
      start_conv(17'd12345, 1'b0, 1'b1);
      repeat (4) @(posedge Clk);
      start_conv(17'd999, 1'b1, 1'b0);
      wait_done(lat, busy_n);
      check("ignored_start_bcd", 64'(bus.Bcd), 64'h012345);

      // Restart from DONE: Valid drops, Bcd holds until the reload.
      start_conv(17'd999, 1'b0, 1'b1);
      check("restart_valid_drop", 64'(bus.Valid), 64'd0);
      check("restart_bcd_kept", 64'(bus.Bcd), 64'h012345);
      wait_done(lat, busy_n);
      check("restart_latency", 64'(lat), 64'd18);

      // Asynchronous reset at cycle 8 of a conversion.
      start_conv(17'd65535, 1'b1, 1'b1);
      repeat (7) @(posedge Clk);
      #3;
      Reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      sb.delete();
      @(negedge Clk);
      Reset = 1'b0;
      start_conv(17'd65536, 1'b0, 1'b1);
      wait_done(lat, busy_n);
      check("post_reset_latency", 64'(lat), 64'd18);

      // Clear and Start on the same edge in DONE: Clear wins.
      @(negedge Clk);
      bus.Clear = 1'b1;
      bus.Start = 1'b1;
      bus.Bin   = 17'd5;
      @(posedge Clk);
      #1;
      bus.Clear = 1'b0;
      bus.Start = 1'b0;
      check_reset_values("clear_start");
      repeat (3) @(posedge Clk);
      #1;
      check("clear_stays_idle_busy", 64'(bus.Busy), 64'd0);
      check("clear_stays_idle_valid", 64'(bus.Valid), 64'd0);

      // Random sweep, led by decimal-boundary corners.
      for (int i = 0; i < 1000; i++) begin
         if (i < 9) b = IN_W'(corners[i]);
         else       b = IN_W'($urandom_range(0, (1 << IN_W) - 1));
         start_conv(b, 1'($urandom_range(0, 1)), 1'b1);
         wait_done(lat, busy_n);
         check("sweep_latency", 64'(lat), 64'd18);
      end

      repeat (2) @(posedge Clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
